mc_ctrl_fsm: RTL

Multi-cycle control unit for the MIPS core. It replaces single-cycle opcode decode with a Moore state machine that sequences fetch, decode, execute, memory and writeback. The FSM stalls on a memory-ready handshake and holds MUL for a parametrised latency. It sits between the instruction register (op/fn fields) and the datapath muxes, register file, ALU and memory interface.

---
 rtl/mc_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control unit for the MIPS core. A Moore FSM steps each
// instruction through fetch, decode, execute, memory and writeback. It stalls
// on the memory-ready handshake and holds MUL for MUL_LAT execute cycles.
//
// Ports
//   clk_87         clock, rising edge
//   rst_87         asynchronous active-high reset
//   op_87, fn_87   opcode / function fields from the instruction register
//   mem_ready_87   memory access completes this cycle
//   pc_write_87    PC load enable
//   pc_src_87      00 ALU, 01 jump target, 10 rs (JR), 11 ALU-out
//   iord_87        memory address select (0 PC, 1 ALU-out)
//   mem_read_87    memory read strobe
//   mem_write_87   memory write strobe
//   ir_write_87    instruction register load
//   reg_write_87   register file write enable
//   reg_dst_87     1 rd, 0 rt
//   mem_to_reg_87  1 MDR, 0 ALU-out
//   alu_src_a_87   0 PC, 1 rs
//   alu_src_b_87   00 rt, 01 4, 10 imm, 11 imm<<2
//   alu_op_87      00 add, 01 sub, 10 funct, 11 opcode decode
//   branch_87      conditional PC write
//   imm_as_reg_87  MUL immediate-field register operand select
//   illegal_87     sticky unsupported-opcode flag
//   state_87       current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int OP_W        = 6,
  parameter int FN_W        = 6,
  parameter int MUL_LAT     = 4,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic            clk_87,
  input  logic            rst_87,
  input  logic [OP_W-1:0] op_87,
  input  logic [FN_W-1:0] fn_87,
  input  logic            mem_ready_87,
  output logic            pc_write_87,
  output logic [1:0]      pc_src_87,
  output logic            iord_87,
  output logic            mem_read_87,
  output logic            mem_write_87,
  output logic            ir_write_87,
  output logic            reg_write_87,
  output logic            reg_dst_87,
  output logic            mem_to_reg_87,
  output logic            alu_src_a_87,
  output logic [1:0]      alu_src_b_87,
  output logic [1:0]      alu_op_87,
  output logic            branch_87,
  output logic            imm_as_reg_87,
  output logic            illegal_87,
  output logic [3:0]      state_87
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    ALU_WB   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JR       = 4'd12,
    MUL_BUSY = 4'd13,
    TRAP     = 4'd14
  } state_t;

  // MIPS opcodes; MUL is the SPECIAL2 encoding.
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(8'h09);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(8'h0A);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(8'h0B);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(8'h0C);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(8'h0D);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(8'h1C);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(8'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(8'h2B);
  localparam logic [FN_W-1:0] FN_JR    = FN_W'(8'h08);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] mul_cnt_reg, mul_cnt_next;
  logic             illegal_reg, illegal_next;

  logic mem_ok;
  logic is_mul, is_rtype, is_add_imm;

  // With waiting disabled every memory state completes in one cycle.
  assign mem_ok     = mem_ready_87 || (MEM_WAIT_EN == 0);
  assign is_mul     = (op_87 == OP_MUL);
  assign is_rtype   = (op_87 == OP_RTYPE);
  assign is_add_imm = (op_87 == OP_ADDI) || (op_87 == OP_ADDIU);

  // State register, MUL latency counter and sticky illegal flag.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      state_reg   <= IDLE;
      mul_cnt_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state_reg;
    mul_cnt_next = mul_cnt_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH:  if (mem_ok) state_next = DECODE;
      DECODE: begin
        if (is_rtype) begin
          state_next = (fn_87 == FN_JR) ? JR : EXEC_R;
        end else begin
          case (op_87)
            OP_MUL:                     state_next = EXEC_R;
            OP_LW, OP_SW:               state_next = MEM_ADDR;
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_SLTI, OP_SLTIU:  state_next = EXEC_I;
            OP_BEQ, OP_BNE:             state_next = BRANCH;
            OP_J:                       state_next = JUMP;
            default:                    state_next = TRAP;
          endcase
        end
      end
      EXEC_R: begin
        // A single-cycle MUL finishes here like any other R-type.
        if (is_mul && (MUL_LAT > 1)) begin
          mul_cnt_next = MUL_LOAD;
          state_next   = MUL_BUSY;
        end else begin
          state_next = ALU_WB;
        end
      end
      MUL_BUSY: begin
        mul_cnt_next = mul_cnt_reg - 1'b1;
        if (mul_cnt_reg == CNT_W'(1)) state_next = ALU_WB;
      end
      EXEC_I:   state_next = ALU_WB;
      ALU_WB:   state_next = FETCH;
      MEM_ADDR: state_next = (op_87 == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ok) state_next = MEM_WB;
      MEM_WB:   state_next = FETCH;
      MEM_WR:   if (mem_ok) state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JUMP:     state_next = FETCH;
      JR:       state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = IDLE;
    endcase
    if (state_next == TRAP) illegal_next = 1'b1;
  end

  // Output decode.
  always_comb begin
    pc_write_87   = 1'b0;
    pc_src_87     = 2'b00;
    iord_87       = 1'b0;
    mem_read_87   = 1'b0;
    mem_write_87  = 1'b0;
    ir_write_87   = 1'b0;
    reg_write_87  = 1'b0;
    reg_dst_87    = 1'b0;
    mem_to_reg_87 = 1'b0;
    alu_src_a_87  = 1'b0;
    alu_src_b_87  = 2'b00;
    alu_op_87     = 2'b00;
    branch_87     = 1'b0;
    imm_as_reg_87 = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read_87  = 1'b1;
        alu_src_b_87 = 2'b01;
        // Only the ready cycle loads IR/PC, and it also leaves FETCH,
        // so each fetch produces exactly one pulse.
        ir_write_87  = mem_ok;
        pc_write_87  = mem_ok;
      end
      DECODE: alu_src_b_87 = 2'b11;
      EXEC_R: begin
        alu_src_a_87  = 1'b1;
        alu_op_87     = 2'b10;
        imm_as_reg_87 = is_mul;
      end
      MUL_BUSY: begin
        alu_src_a_87  = 1'b1;
        alu_op_87     = 2'b10;
        imm_as_reg_87 = 1'b1;
      end
      EXEC_I: begin
        alu_src_a_87 = 1'b1;
        alu_src_b_87 = 2'b10;
        alu_op_87    = is_add_imm ? 2'b00 : 2'b11;
      end
      ALU_WB: begin
        reg_write_87  = 1'b1;
        reg_dst_87    = is_rtype || is_mul;
        imm_as_reg_87 = is_mul;
      end
      MEM_ADDR: begin
        alu_src_a_87 = 1'b1;
        alu_src_b_87 = 2'b10;
      end
      MEM_RD: begin
        mem_read_87 = 1'b1;
        iord_87     = 1'b1;
      end
      MEM_WB: begin
        reg_write_87  = 1'b1;
        mem_to_reg_87 = 1'b1;
      end
      MEM_WR: begin
        mem_write_87 = 1'b1;
        iord_87      = 1'b1;
      end
      BRANCH: begin
        alu_src_a_87 = 1'b1;
        alu_op_87    = 2'b01;
        branch_87    = 1'b1;
        pc_src_87    = 2'b11;
      end
      JUMP: begin
        pc_write_87 = 1'b1;
        pc_src_87   = 2'b01;
      end
      JR: begin
        pc_write_87 = 1'b1;
        pc_src_87   = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_87 = illegal_reg;
  assign state_87   = state_reg;

endmodule
